// File: rtl/mem_wb_pkg.sv
// -----------------------------------------------------------------------------
// mem_wb_pkg
// Shared types and constants for the MEM->WB pipeline register.
//   mem_wb_payload_t : write-back payload at the core's default widths
//   skid_state_t     : occupancy of the elastic register (EMPTY / ONE / TWO)
//   ZERO_REG         : architectural zero register index (writes are dropped)
// -----------------------------------------------------------------------------
package mem_wb_pkg;

  localparam int PKG_DATA_W = 32;
  localparam int PKG_REG_W  = 5;
  localparam int ZERO_REG   = 0;

  typedef struct packed {
    logic                  wb_en;
    logic                  mem_r_en;
    logic [PKG_DATA_W-1:0] alu_result;
    logic [PKG_DATA_W-1:0] mem_read_value;
    logic [PKG_REG_W-1:0]  dest;
  } mem_wb_payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// -----------------------------------------------------------------------------
// pipe_skid_buf
// Generic two-entry elastic register with a valid/ready handshake on both
// sides. The main entry drives the outputs; the skid entry absorbs the one
// extra beat that arrives while in_ready (a flop) has not yet dropped.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   flush                synchronous discard of both entries (top priority)
//   in_valid/in_ready    upstream handshake, in_ready registered
//   in_data              upstream payload (W bits)
//   out_valid/out_ready  downstream handshake, out_valid registered
//   out_data             head entry payload (registered)
// -----------------------------------------------------------------------------
module pipe_skid_buf
  import mem_wb_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_t  state_r;
  skid_state_t  state_nx_s;
  logic         main_valid_r;
  logic         skid_valid_r;
  logic         in_ready_r;
  logic [W-1:0] main_data_r;
  logic [W-1:0] skid_data_r;

  logic         accept_s;
  logic         pop_s;
  logic         main_load_in_s;
  logic         main_load_skid_s;
  logic         skid_load_s;

  assign accept_s = in_valid & in_ready_r;
  assign pop_s    = main_valid_r & out_ready;

  // Next-state and entry-load selection; flush overrides every transition.
  always_comb begin
    state_nx_s       = state_r;
    main_load_in_s   = 1'b0;
    main_load_skid_s = 1'b0;
    skid_load_s      = 1'b0;
    if (flush) begin
      state_nx_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            state_nx_s     = ONE;
            main_load_in_s = 1'b1;
          end else begin
            state_nx_s = EMPTY;
          end
        end
        ONE: begin
          if (accept_s && pop_s) begin
            state_nx_s     = ONE;
            main_load_in_s = 1'b1;
          end else if (accept_s) begin
            // Head is stalled: park the new beat in the skid entry.
            state_nx_s  = TWO;
            skid_load_s = 1'b1;
          end else if (pop_s) begin
            state_nx_s = EMPTY;
          end else begin
            state_nx_s = ONE;
          end
        end
        TWO: begin
          if (pop_s) begin
            state_nx_s       = ONE;
            main_load_skid_s = 1'b1;
          end else begin
            state_nx_s = TWO;
          end
        end
        default: begin
          state_nx_s = EMPTY;
        end
      endcase
    end
  end

  // State, entry valid bits and the registered in_ready flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= EMPTY;
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
    end else begin
      state_r      <= state_nx_s;
      main_valid_r <= (state_nx_s != EMPTY);
      skid_valid_r <= (state_nx_s == TWO);
      // in_ready mirrors "skid not full" one cycle ahead, so it is a flop.
      in_ready_r   <= (state_nx_s != TWO);
    end
  end

  // Payload storage for the main (head) and skid entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_data_r <= {W{1'b0}};
      skid_data_r <= {W{1'b0}};
    end else begin
      if (main_load_in_s) begin
        main_data_r <= in_data;
      end else if (main_load_skid_s) begin
        main_data_r <= skid_data_r;
      end else begin
        main_data_r <= main_data_r;
      end
      if (skid_load_s) begin
        skid_data_r <= in_data;
      end else begin
        skid_data_r <= skid_data_r;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = main_valid_r;
  assign out_data  = main_data_r;

  // skid_valid_r documents occupancy; state_r carries the same information.
  logic unused_skid_valid_s;
  assign unused_skid_valid_s = skid_valid_r;

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// -----------------------------------------------------------------------------
// mem_wb_pipe_reg
// Elastic MEM->WB pipeline register. Wraps pipe_skid_buf and adds register-0
// write suppression on capture, wb_en gating with out_valid, and the
// pre-muxed write-back data.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   flush                    synchronous discard of held entries
//   in_valid / in_ready      MEM-side handshake (in_ready registered)
//   wb_en_in, mem_r_en_in,
//   alu_result_in,
//   mem_read_value_in,
//   dest_in                  incoming write-back payload
//   out_valid / out_ready    WB-side handshake
//   wb_en, mem_r_en,
//   alu_result,
//   mem_read_value, dest     head entry payload (wb_en gated by out_valid)
//   wb_data                  mem_r_en ? mem_read_value : alu_result
// -----------------------------------------------------------------------------
module mem_wb_pipe_reg
  import mem_wb_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int REG_W         = 5,
  parameter bit ZERO_SUPPRESS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] mem_read_value_in,
  input  logic [REG_W-1:0]  dest_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] mem_read_value,
  output logic [REG_W-1:0]  dest,
  output logic [DATA_W-1:0] wb_data
);

  localparam int               PAYLOAD_W = 2 + 2 * DATA_W + REG_W;
  localparam logic [REG_W-1:0] ZERO_DEST = REG_W'(ZERO_REG);

  logic                 wb_en_cap_s;
  logic [PAYLOAD_W-1:0] in_payload_s;
  logic [PAYLOAD_W-1:0] head_payload_s;
  logic                 head_wb_en_s;

  // Writes to the zero register are architecturally void; drop them early.
  always_comb begin
    wb_en_cap_s = wb_en_in;
    if (ZERO_SUPPRESS && (dest_in == ZERO_DEST)) begin
      wb_en_cap_s = 1'b0;
    end else begin
      wb_en_cap_s = wb_en_in;
    end
  end

  assign in_payload_s = {wb_en_cap_s, mem_r_en_in, alu_result_in,
                         mem_read_value_in, dest_in};

  pipe_skid_buf #(
    .W (PAYLOAD_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head_payload_s)
  );

  assign {head_wb_en_s, mem_r_en, alu_result, mem_read_value, dest} = head_payload_s;

  // Stale payload may linger in an invalid entry, so wb_en must be qualified.
  assign wb_en = head_wb_en_s & out_valid;

  // Write-back source select: one 2:1 mux after the head flops.
  always_comb begin
    wb_data = alu_result;
    if (mem_r_en) begin
      wb_data = mem_read_value;
    end else begin
      wb_data = alu_result;
    end
  end

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
module tb_mem_wb_pipe_reg;

  typedef struct {
    logic        wb_en;
    logic        mem_r_en;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [4:0]  dest;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        wb_en_in;
  logic        mem_r_en_in;
  logic [31:0] alu_result_in;
  logic [31:0] mem_read_value_in;
  logic [4:0]  dest_in;
  logic        out_ready;

  logic        in_ready, out_valid, wb_en, mem_r_en;
  logic [31:0] alu_result, mem_read_value, wb_data;
  logic [4:0]  dest;

  logic        nz_in_ready, nz_out_valid, nz_wb_en, nz_mem_r_en;
  logic [31:0] nz_alu_result, nz_mem_read_value, nz_wb_data;
  logic [4:0]  nz_dest;

  int n_cmp = 0;
  int n_err = 0;
  ent_t q[$];

  always #5 clk = ~clk;

  mem_wb_pipe_reg #(.DATA_W(32), .REG_W(5), .ZERO_SUPPRESS(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .alu_result_in(alu_result_in),
    .mem_read_value_in(mem_read_value_in), .dest_in(dest_in),
    .out_valid(out_valid), .out_ready(out_ready), .wb_en(wb_en), .mem_r_en(mem_r_en),
    .alu_result(alu_result), .mem_read_value(mem_read_value), .dest(dest),
    .wb_data(wb_data)
  );

  mem_wb_pipe_reg #(.DATA_W(32), .REG_W(5), .ZERO_SUPPRESS(1'b0)) dut_nz (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(nz_in_ready),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .alu_result_in(alu_result_in),
    .mem_read_value_in(mem_read_value_in), .dest_in(dest_in),
    .out_valid(nz_out_valid), .out_ready(out_ready), .wb_en(nz_wb_en),
    .mem_r_en(nz_mem_r_en), .alu_result(nz_alu_result),
    .mem_read_value(nz_mem_read_value), .dest(nz_dest), .wb_data(nz_wb_data)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic mr, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [4:0] d, input logic fl,
                       input logic ordy);
    in_valid = v; wb_en_in = we; mem_r_en_in = mr; alu_result_in = alu;
    mem_read_value_in = mem; dest_in = d; flush = fl; out_ready = ordy;
  endtask

  // Compare both DUTs against the queue-based reference (capacity two).
  task automatic check_outputs();
    ent_t e;
    check_val("out_valid", 64'(out_valid), 64'(q.size() != 0));
    check_val("in_ready", 64'(in_ready), 64'(q.size() < 2));
    check_val("nz_out_valid", 64'(nz_out_valid), 64'(q.size() != 0));
    check_val("nz_in_ready", 64'(nz_in_ready), 64'(q.size() < 2));
    if (q.size() != 0) begin
      e = q[0];
      check_val("dest", 64'(dest), 64'(e.dest));
      check_val("alu_result", 64'(alu_result), 64'(e.alu));
      check_val("mem_read_value", 64'(mem_read_value), 64'(e.mem));
      check_val("mem_r_en", 64'(mem_r_en), 64'(e.mem_r_en));
      check_val("wb_en", 64'(wb_en), 64'(e.wb_en && (e.dest != 5'd0)));
      check_val("nz_wb_en", 64'(nz_wb_en), 64'(e.wb_en));
      check_val("wb_data", 64'(wb_data), 64'(e.mem_r_en ? e.mem : e.alu));
      check_val("nz_wb_data", 64'(nz_wb_data), 64'(e.mem_r_en ? e.mem : e.alu));
    end else begin
      check_val("wb_en_idle", 64'(wb_en), 64'd0);
      check_val("nz_wb_en_idle", 64'(nz_wb_en), 64'd0);
    end
  endtask

  // One clock: model the handshake with the current inputs, then check #1 later.
  task automatic cycle();
    ent_t cur;
    bit   acc;
    bit   pp;
    cur.wb_en = wb_en_in; cur.mem_r_en = mem_r_en_in; cur.alu = alu_result_in;
    cur.mem = mem_read_value_in; cur.dest = dest_in;
    acc = in_valid && (q.size() < 2);
    pp  = out_ready && (q.size() != 0);
    @(posedge clk);
    #1;
    if (flush) begin
      q.delete();
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(cur);
    end
    check_outputs();
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    #12;
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_in_ready", 64'(in_ready), 64'd1);
    check_val("rst_wb_en", 64'(wb_en), 64'd0);
    check_val("rst_mem_r_en", 64'(mem_r_en), 64'd0);
    check_val("rst_alu", 64'(alu_result), 64'd0);
    check_val("rst_mem", 64'(mem_read_value), 64'd0);
    check_val("rst_dest", 64'(dest), 64'd0);
    check_val("rst_wb_data", 64'(wb_data), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Streaming: four back-to-back entries, each visible one cycle later.
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 1'b1, 1'b0, 32'(k * 16), 32'h0, 5'(k), 1'b0, 1'b1);
      cycle();
      check_val("stream_dest", 64'(dest), 64'(k));
      check_val("stream_alu", 64'(alu_result), 64'(k * 16));
      check_val("stream_in_ready", 64'(in_ready), 64'd1);
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    cycle();

    // Stall absorb: head dest 5, then stall while dest 7 arrives.
    drive(1'b1, 1'b1, 1'b0, 32'h55, 32'h0, 5'd5, 1'b0, 1'b1);
    cycle();
    drive(1'b1, 1'b1, 1'b0, 32'hAA, 32'h0, 5'd7, 1'b0, 1'b0);
    cycle();
    check_val("stall_in_ready", 64'(in_ready), 64'd0);
    check_val("stall_head", 64'(dest), 64'd5);
    drive(1'b1, 1'b1, 1'b0, 32'hCC, 32'h0, 5'd9, 1'b0, 1'b0);
    cycle();
    check_val("stall_hold", 64'(alu_result), 64'h55);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    cycle();
    check_val("skid_emerges", 64'(dest), 64'd7);
    cycle();
    check_val("drained", 64'(out_valid), 64'd0);

    // Load mux.
    drive(1'b1, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 5'd3, 1'b0, 1'b1);
    cycle();
    check_val("load_wb_data", 64'(wb_data), 64'hDEADBEEF);
    drive(1'b1, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 5'd3, 1'b0, 1'b1);
    cycle();
    check_val("alu_wb_data", 64'(wb_data), 64'h100);

    // Zero suppression.
    drive(1'b1, 1'b1, 1'b0, 32'h7, 32'h0, 5'd0, 1'b0, 1'b1);
    cycle();
    check_val("zs_wb_en", 64'(wb_en), 64'd0);
    check_val("nzs_wb_en", 64'(nz_wb_en), 64'd1);

    // Flush in TWO together with a new beat.
    drive(1'b1, 1'b1, 1'b0, 32'h11, 32'h0, 5'd11, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 1'b1, 1'b0, 32'h12, 32'h0, 5'd12, 1'b0, 1'b0);
    cycle();
    check_val("pre_flush_full", 64'(in_ready), 64'd0);
    drive(1'b1, 1'b1, 1'b0, 32'h1F, 32'h0, 5'd31, 1'b1, 1'b0);
    cycle();
    check_val("flush_out_valid", 64'(out_valid), 64'd0);
    check_val("flush_in_ready", 64'(in_ready), 64'd1);
    check_val("flush_wb_en", 64'(wb_en), 64'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    cycle();
    check_val("flush_dropped", 64'(out_valid), 64'd0);

    // Async reset while holding two entries.
    drive(1'b1, 1'b1, 1'b0, 32'h21, 32'h0, 5'd21, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 1'b1, 1'b0, 32'h22, 32'h0, 5'd22, 1'b0, 1'b0);
    cycle();
    #3;
    rst = 1'b1;
    #1;
    check_val("arst_out_valid", 64'(out_valid), 64'd0);
    check_val("arst_wb_en", 64'(wb_en), 64'd0);
    check_val("arst_dest", 64'(dest), 64'd0);
    check_val("arst_in_ready", 64'(in_ready), 64'd1);
    q.delete();
    #3;
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h33, 32'h0, 5'd13, 1'b0, 1'b1);
    cycle();
    check_val("post_rst_dest", 64'(dest), 64'd13);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom), $urandom, $urandom,
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom_range(0, 31) == 0,
            $urandom_range(0, 9) < 6);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
